// File: rtl/cnn_pkg.sv
// Shared conv-layer definitions: default line geometry, packed-line offset helper and the
// write-back FSM state type.
package cnn_pkg;

  localparam int unsigned WORDS_PER_MAP = 8;    // MAP_SIZE / ROWS_PER_WORD at default geometry
  localparam int unsigned LINE_WIDTH    = 256;  // DATA_WIDTH * MAP_SIZE at default geometry

  // LSB of pixel column j of packed row k inside one memory word.
  function automatic int unsigned line_lsb(input int unsigned k, input int unsigned j,
                                           input int unsigned data_width,
                                           input int unsigned line_width);
    return j * data_width + k * line_width;
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StPack,
    StWrite,
    StDone
  } wr_state_e;

endpackage

// File: rtl/ofm_line_writer_if.sv
// Waitrequest-style feature-memory write port carrying packed ofm lines.
interface ofm_line_writer_if #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned MAP_SIZE      = 32,
  parameter int unsigned ROWS_PER_WORD = 4,
  parameter int unsigned ADDR_WIDTH    = 10
);
  localparam int unsigned WordWidth = DATA_WIDTH * MAP_SIZE * ROWS_PER_WORD;

  logic                  ofm_wr;
  logic [ADDR_WIDTH-1:0] ofm_addr;
  logic [WordWidth-1:0]  ofm_writedata;
  logic                  ofm_waitrequest;

  modport master (
    output ofm_wr,
    output ofm_addr,
    output ofm_writedata,
    input  ofm_waitrequest
  );

  modport slave (
    input  ofm_wr,
    input  ofm_addr,
    input  ofm_writedata,
    output ofm_waitrequest
  );
endinterface

// File: rtl/ofm_line_writer_requant_sat.sv
// One-pixel requantizer: arithmetic right shift then saturate to DATA_WIDTH.
// With RELU_EN defined, negative results clamp to zero first.
module ofm_line_writer_requant_sat #(
  parameter int unsigned BUF_WIDTH   = 26,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SHIFT_WIDTH = 5
) (
  input  logic [BUF_WIDTH-1:0]   i_pix,
  input  logic [SHIFT_WIDTH-1:0] i_shift,
  output logic [DATA_WIDTH-1:0]  o_q
);
  localparam logic signed [BUF_WIDTH-1:0] MaxVal = BUF_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [BUF_WIDTH-1:0] MinVal = -BUF_WIDTH'(2 ** (DATA_WIDTH - 1));

  logic signed [BUF_WIDTH-1:0] w_s;

  assign w_s = $signed(i_pix) >>> i_shift;

  always_comb begin
    o_q = w_s[DATA_WIDTH-1:0];
`ifdef RELU_EN
    if (w_s[BUF_WIDTH-1]) begin
      o_q = '0;
    end else if (w_s > MaxVal) begin
      o_q = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    end
`else
    if (w_s > MaxVal) begin
      o_q = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    end else if (w_s < MinVal) begin
      o_q = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    end
`endif
  end

endmodule

// File: rtl/ofm_line_writer.sv
// Conv write-back: snapshots the ofm map, requantizes it and writes packed lines to feature
// memory one word at a time. Define RELU_EN to clamp negative pixels to zero.
module ofm_line_writer
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned BUF_WIDTH     = 26,
  parameter int unsigned MAP_SIZE      = 32,
  parameter int unsigned ROWS_PER_WORD = 4,
  parameter int unsigned CH_WIDTH      = 7,
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned SHIFT_WIDTH   = 5
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  input  logic [BUF_WIDTH*MAP_SIZE*MAP_SIZE-1:0]  ofm,
  input  logic [CH_WIDTH-1:0]                     och,
  input  logic [SHIFT_WIDTH-1:0]                  shift,
  ofm_line_writer_if.master                       mem,
  output logic                                    busy,
  output logic                                    done
);
  localparam int unsigned Words     = MAP_SIZE / ROWS_PER_WORD;
  localparam int unsigned Line      = DATA_WIDTH * MAP_SIZE;
  localparam int unsigned WordWidth = Line * ROWS_PER_WORD;
  localparam int unsigned WBits     = (Words > 1) ? $clog2(Words) : 1;
  localparam int unsigned SnapWidth = BUF_WIDTH * MAP_SIZE * MAP_SIZE;

  wr_state_e              r_state, w_state_d;
  logic [WBits-1:0]       r_w, w_w_d;
  logic                   r_wr, w_wr_d;
  logic [ADDR_WIDTH-1:0]  r_addr, w_addr_d;
  logic [WordWidth-1:0]   r_data, w_data_d;
  logic                   r_busy, w_busy_d;
  logic                   r_done, w_done_d;
  logic                   w_capture;
  logic [SnapWidth-1:0]   r_snap;
  logic [CH_WIDTH-1:0]    r_och;
  logic [SHIFT_WIDTH-1:0] r_shift;
  logic [WordWidth-1:0]   w_line;
  logic                   w_accept;

  // Word-select mux: word r_w covers map rows r_w*ROWS_PER_WORD .. +ROWS_PER_WORD-1.
  for (genvar k = 0; k < ROWS_PER_WORD; k++) begin : g_row
    for (genvar j = 0; j < MAP_SIZE; j++) begin : g_col
      localparam int unsigned Lsb = line_lsb(k, j, DATA_WIDTH, Line);
      logic [31:0]           w_base;
      logic [BUF_WIDTH-1:0]  w_pix;

      assign w_base = ((32'(r_w) * ROWS_PER_WORD + k) * MAP_SIZE + j) * BUF_WIDTH;
      assign w_pix  = r_snap[w_base +: BUF_WIDTH];

      ofm_line_writer_requant_sat #(
        .BUF_WIDTH  (BUF_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT_WIDTH(SHIFT_WIDTH)
      ) u_rq (
        .i_pix  (w_pix),
        .i_shift(r_shift),
        .o_q    (w_line[Lsb +: DATA_WIDTH])
      );
    end
  end

  assign w_accept = r_wr && !mem.ofm_waitrequest;

  always_comb begin
    w_state_d = r_state;
    w_w_d     = r_w;
    w_wr_d    = r_wr;
    w_addr_d  = r_addr;
    w_data_d  = r_data;
    w_busy_d  = r_busy;
    w_done_d  = 1'b0;
    w_capture = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_capture = 1'b1;
          w_w_d     = '0;
          w_busy_d  = 1'b1;
          w_state_d = StPack;
        end
      end
      StPack: begin
        w_addr_d  = ADDR_WIDTH'(r_och) * ADDR_WIDTH'(Words) + ADDR_WIDTH'(r_w);
        w_data_d  = w_line;
        w_wr_d    = 1'b1;
        w_state_d = StWrite;
      end
      StWrite: begin
        if (w_accept) begin
          w_wr_d = 1'b0;
          if (r_w == WBits'(Words - 1)) begin
            w_done_d  = 1'b1;
            w_state_d = StDone;
          end else begin
            w_w_d     = r_w + 1'b1;
            w_state_d = StPack;
          end
        end
      end
      StDone: begin
        w_busy_d  = 1'b0;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_w     <= '0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_w     <= w_w_d;
      r_wr    <= w_wr_d;
      r_addr  <= w_addr_d;
      r_data  <= w_data_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap  <= '0;
      r_och   <= '0;
      r_shift <= '0;
    end else if (w_capture) begin
      r_snap  <= ofm;
      r_och   <= och;
      r_shift <= shift;
    end
  end

  assign mem.ofm_wr        = r_wr;
  assign mem.ofm_addr      = r_addr;
  assign mem.ofm_writedata = r_data;
  assign busy              = r_busy;
  assign done              = r_done;

endmodule

// File: tb/tb_ofm_line_writer.sv
// Directed bench for ofm_line_writer: latency, requant/packing, stalls, abort and ignored start.
module tb_ofm_line_writer;
  import cnn_pkg::*;

  localparam int DW    = 8;
  localparam int BW    = 26;
  localparam int MAP   = 32;
  localparam int RPW   = 4;
  localparam int CHW   = 7;
  localparam int AW    = 10;
  localparam int SW    = 5;
  localparam int WORDW = DW * MAP * RPW;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  logic [BW*MAP*MAP-1:0]  ofm = '0;
  logic [BW*MAP*MAP-1:0]  model_ofm = '0;
  logic [CHW-1:0]         och = '0;
  logic [SW-1:0]          shift = '0;
  logic                   waitreq = 1'b0;
  logic                   busy, done;

  ofm_line_writer_if #(.DATA_WIDTH(DW), .MAP_SIZE(MAP), .ROWS_PER_WORD(RPW), .ADDR_WIDTH(AW))
    mem_if ();
  assign mem_if.ofm_waitrequest = waitreq;

  ofm_line_writer #(
    .DATA_WIDTH(DW), .BUF_WIDTH(BW), .MAP_SIZE(MAP), .ROWS_PER_WORD(RPW),
    .CH_WIDTH(CHW), .ADDR_WIDTH(AW), .SHIFT_WIDTH(SW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .ofm  (ofm),
    .och  (och),
    .shift(shift),
    .mem  (mem_if.master),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [AW-1:0]    acc_addr [WORDS_PER_MAP];
  logic [WORDW-1:0] acc_data [WORDS_PER_MAP];
  int               acc_cyc  [WORDS_PER_MAP];
  int               n_acc, done_cyc, wr_cycles;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rq(input logic signed [BW-1:0] x, input int sh);
    longint s;
    s = longint'(x) >>> sh;
`ifdef RELU_EN
    if (s < 0) s = 0;
`endif
    if (s > 127) return 8'h7f;
    if (s < -128) return 8'h80;
    return s[7:0];
  endfunction

  function automatic logic [WORDW-1:0] exp_word(input int w, input int sh);
    logic [WORDW-1:0] r;
    r = '0;
    for (int k = 0; k < RPW; k++)
      for (int j = 0; j < MAP; j++)
        r[k*LINE_WIDTH + j*DW +: DW] = rq(model_ofm[((w*RPW+k)*MAP+j)*BW +: BW], sh);
    return r;
  endfunction

  task automatic fill_const(input int v);
    for (int p = 0; p < MAP*MAP; p++) ofm[p*BW +: BW] = BW'(v);
  endtask

  task automatic fill_ramp();
    for (int p = 0; p < MAP*MAP; p++) ofm[p*BW +: BW] = BW'(p);
  endtask

  // Issues one start and follows the transfer cycle by cycle (cycle 0 = start cycle).
  task automatic run_map(input int o, input int sh, input int stall_lo, input int restart_at,
                         input int abort_at);
    bit               fin;
    bit               holding;
    logic [AW-1:0]    h_addr;
    logic [WORDW-1:0] h_data;
    n_acc = 0; done_cyc = -1; wr_cycles = 0; holding = 0; fin = 0;
    h_addr = '0; h_data = '0;
    model_ofm = ofm;
    @(negedge clk);
    och = CHW'(o); shift = SW'(sh); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy c1", {63'b0, busy}, 64'd1);
    for (int n = 1; n < 200 && !fin; n++) begin
      start = (n == restart_at);
      if (n == restart_at) begin
        ofm = ~ofm; och = CHW'(o + 1); shift = '0;
      end
      waitreq = (stall_lo >= 0 && n >= stall_lo && n < stall_lo + 5);
      #1;
      if (n == abort_at) begin
        check_eq("wr before abort", {63'b0, mem_if.ofm_wr}, 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort wr", {63'b0, mem_if.ofm_wr}, 64'd0);
        check_eq("abort busy", {63'b0, busy}, 64'd0);
        check_eq("abort done", {63'b0, done}, 64'd0);
        fin = 1;
      end else begin
        if (mem_if.ofm_wr) begin
          wr_cycles++;
          if (waitreq) begin
            if (holding) begin
              check_eq("stall addr", 64'(mem_if.ofm_addr), 64'(h_addr));
              check_eq("stall data", {63'b0, mem_if.ofm_writedata == h_data}, 64'd1);
            end
            h_addr = mem_if.ofm_addr; h_data = mem_if.ofm_writedata; holding = 1;
          end else begin
            if (n_acc < WORDS_PER_MAP) begin
              acc_addr[n_acc] = mem_if.ofm_addr;
              acc_data[n_acc] = mem_if.ofm_writedata;
              acc_cyc[n_acc]  = n;
            end
            n_acc++;
            holding = 0;
          end
        end
        if (done) begin
          done_cyc = n; fin = 1;
        end
      end
      @(negedge clk);
    end
    start = 1'b0; waitreq = 1'b0;
    if (!fin) check_eq("timeout", 64'd0, 64'd1);
    if (abort_at >= 0) rst_n = 1'b1;
  endtask

  task automatic verify_map(input int o, input int sh, input int exp_done);
    check_eq("accept count", 64'(n_acc), 64'(WORDS_PER_MAP));
    check_eq("done cycle", 64'(done_cyc), 64'(exp_done));
    for (int w = 0; w < WORDS_PER_MAP && w < n_acc; w++) begin
      logic [WORDW-1:0] e;
      e = exp_word(w, sh);
      check_eq($sformatf("addr w%0d", w), 64'(acc_addr[w]), 64'(o * WORDS_PER_MAP + w));
      for (int c = 0; c < WORDW / 64; c++)
        check_eq($sformatf("data w%0d c%0d", w, c), acc_data[w][c*64 +: 64], e[c*64 +: 64]);
    end
  endtask

  initial begin
    logic [WORDW-1:0] d;
    #2;
    check_eq("rst wr", {63'b0, mem_if.ofm_wr}, 64'd0);
    check_eq("rst addr", 64'(mem_if.ofm_addr), 64'd0);
    check_eq("rst data", {63'b0, mem_if.ofm_writedata == '0}, 64'd1);
    check_eq("rst busy", {63'b0, busy}, 64'd0);
    check_eq("rst done", {63'b0, done}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Positive saturation: 256 >>> 1 = 128 clips to 127.
    fill_const(256);
    run_map(3, 1, -1, -1, -1);
    verify_map(3, 1, 17);
    check_eq("first wr cycle", 64'(acc_cyc[0]), 64'd2);
    d = acc_data[7];
    check_eq("sat byte", 64'(d[WORDW-8 +: 8]), 64'h7f);
    check_eq("idle busy", {63'b0, busy}, 64'd0);

    // Ramp packing: pixel (5,7)=167 >>> 3 = 20.
    fill_ramp();
    run_map(0, 3, -1, -1, -1);
    verify_map(0, 3, 17);
    d = acc_data[1];
    check_eq("ramp (5,7)", 64'(d[319:312]), 64'h14);
    d = acc_data[0];
    check_eq("ramp (0,0)", 64'(d[7:0]), 64'h00);

    // Negative saturation (or ReLU zero).
    fill_const(-1000);
    run_map(1, 2, -1, -1, -1);
    verify_map(1, 2, 17);
    d = acc_data[3];
`ifdef RELU_EN
    check_eq("neg byte", 64'(d[15:8]), 64'h00);
`else
    check_eq("neg byte", 64'(d[15:8]), 64'h80);
`endif

    // Five-cycle stall on word 2.
    fill_ramp();
    run_map(5, 0, 6, -1, -1);
    verify_map(5, 0, 22);
    check_eq("stall wr cycles", 64'(wr_cycles), 64'd13);

    // Reset during WRITE of word 4, then a full map on the last channel.
    fill_const(300);
    run_map(2, 1, -1, -1, 10);
    check_eq("abort accepts", 64'(n_acc), 64'd4);
    fill_const(-77);
    run_map(127, 0, -1, -1, -1);
    verify_map(127, 0, 17);
    check_eq("last addr", 64'(acc_addr[7]), 64'd1023);

    // Start while busy is ignored; data comes from the first snapshot.
    fill_ramp();
    run_map(4, 2, -1, 5, -1);
    verify_map(4, 2, 17);
    @(negedge clk);
    check_eq("post idle wr", {63'b0, mem_if.ofm_wr}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
